// File: rtl/crypt_stream_framer.sv
// rtl/crypt_stream_framer.sv - byte-stream framer around the combinational Cryptographer core
//
// Collects 16 input bytes plus a per-frame key and mode into a held 128-bit state.
// It then waits SETTLE_CYCLES for the combinational core, captures its 128-bit result,
// and streams the result out as 16 bytes.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_data/in_valid/in_ready       input byte stream (valid/ready handshake)
//   key_in, mode_in                 frame key and mode, sampled with byte 0
//   blk_out, key_out, mode_out      held frame state/key/mode driven to the core
//   res_in                          core result (byte 0 in bits [127:120])
//   out_data/out_valid/out_ready    output byte stream (valid/ready handshake)
//   busy                            a frame is in progress
//   frames_done                     wrapping count of completed frames
module crypt_stream_framer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [9:0]   key_in,
  input  logic         mode_in,
  output logic [127:0] blk_out,
  output logic [9:0]   key_out,
  output logic         mode_out,
  input  logic [127:0] res_in,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [15:0]  frames_done
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]   r_state;
  logic [3:0]   r_idx;
  logic [7:0]   r_cnt;
  logic [127:0] r_blk;
  logic [127:0] r_res;
  logic [9:0]   r_key;
  logic         r_mode;
  logic         r_out_valid;
  logic [15:0]  r_frames_done;

  logic         w_load;
  logic         w_in_fire;
  logic         w_out_fire;
  logic [6:0]   w_bit_base;

  assign w_load = (r_state == ST_LOAD);

  // Byte i occupies bits [127-8i -: 8]; one index serves both the load and drain
  // phases because they never overlap.
  assign w_bit_base = {4'd15 - r_idx, 3'b000};

  // Decoded outputs are forced low while reset is asserted.
  assign in_ready = rst_n & w_load;
  assign busy     = rst_n & (~w_load | (r_idx != 4'd0));

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign blk_out     = r_blk;
  assign key_out     = r_key;
  assign mode_out    = r_mode;
  assign out_valid   = r_out_valid;
  assign frames_done = r_frames_done;
  assign out_data    = r_res[w_bit_base +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_LOAD;
      r_idx         <= 4'd0;
      r_cnt         <= 8'd0;
      r_blk         <= 128'd0;
      r_res         <= 128'd0;
      r_key         <= 10'd0;
      r_mode        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frames_done <= 16'd0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_blk[w_bit_base +: 8] <= in_data;
            if (r_idx == 4'd0) begin
              r_key  <= key_in;
              r_mode <= mode_in;
            end
            if (r_idx == 4'd15) begin
              r_state <= ST_SETTLE;
              r_cnt   <= SETTLE_LOAD;
              r_idx   <= 4'd0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        ST_SETTLE: begin
          // The core input has been stable for SETTLE_CYCLES when the counter hits 0.
          if (r_cnt == 8'd0) begin
            r_res       <= res_in;
            r_out_valid <= 1'b1;
            r_state     <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (r_idx == 4'd15) begin
              r_out_valid   <= 1'b0;
              r_idx         <= 4'd0;
              r_frames_done <= r_frames_done + 16'd1;
              r_state       <= ST_LOAD;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: begin
          r_state <= ST_LOAD;
          r_idx   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crypt_stream_framer.sv
// tb/tb_crypt_stream_framer.sv - self-checking bench for crypt_stream_framer
module tb_crypt_stream_framer;

  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [9:0]   key_in = 10'd0;
  logic         mode_in = 1'b0;
  logic [127:0] blk_out;
  logic [9:0]   key_out;
  logic         mode_out;
  logic [127:0] res_in;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic [15:0]  frames_done;

  // Core stub.
  assign res_in = blk_out ^ {16{8'hA5}};

  crypt_stream_framer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .mode_in(mode_in),
    .blk_out(blk_out), .key_out(key_out), .mode_out(mode_out),
    .res_in(res_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_frames = 16'd0;
  logic [7:0]  fb [16];
  logic [7:0]  nxt_byte0 = 8'd0;
  logic [9:0]  nxt_key = 10'd0;
  logic        nxt_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full frame: load 16 bytes, measure settle latency, drain and compare
  // against the stub result. rmode: 0 = ready high, 1 = 1,0,0 pattern with a
  // 20-cycle stall at byte 7, 2 = random ready.
  task automatic run_frame(input logic [7:0] b [16], input logic [9:0] key, input logic mode,
                           input bit in_stalls, input int rmode, input bit b2b_in, input bit chain_out);
    int w;
    int lat;
    int j;
    int cyc;
    int pat;
    int long_left;
    bit have_prev;
    logic [7:0] prev;
    logic r;
    for (int i = 0; i < 16; i++) begin
      if (in_stalls && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          tick();
          chk("stall_busy", busy, 1'b1);
        end
      end
      in_data  = b[i];
      in_valid = 1'b1;
      key_in   = (i == 0) ? key : 10'h3FF;
      mode_in  = (i == 0) ? mode : 1'b1;
      w = 0;
      while (!in_ready && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) chk("in_ready_timeout", 1'b0, 1'b1);
      if (i == 0 && b2b_in) chk("b2b_byte0_wait", w, 0);
      tick();
      chk("blk_byte", blk_out[8*(15-i) +: 8], b[i]);
      chk("key_out", key_out, key);
      chk("mode_out", mode_out, mode);
    end
    in_valid = 1'b0;
    chk("in_ready_settle", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("latency", lat, SETTLE);
    chk("blk_held", blk_out, {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7],
                              b[8], b[9], b[10], b[11], b[12], b[13], b[14], b[15]});
    j = 0;
    cyc = 0;
    pat = 0;
    long_left = 20;
    have_prev = 1'b0;
    prev = 8'd0;
    while (j < 16 && cyc < 400) begin
      if (rmode == 0) begin
        r = 1'b1;
      end else if (rmode == 1) begin
        if (j == 7 && long_left > 0) begin
          r = 1'b0;
          long_left--;
        end else begin
          r = (pat % 3 == 0);
          pat++;
        end
      end else begin
        r = 1'($urandom_range(0, 1));
      end
      out_ready = r;
      if (chain_out) begin
        in_valid = 1'b1;
        in_data  = nxt_byte0;
        key_in   = nxt_key;
        mode_in  = nxt_mode;
      end
      chk("in_ready_drain", in_ready, 1'b0);
      chk("out_valid_drain", out_valid, 1'b1);
      chk("busy_drain", busy, 1'b1);
      if (have_prev) chk("stall_stable", out_data, prev);
      if (r) begin
        chk("out_byte", out_data, b[j] ^ 8'hA5);
        j++;
        have_prev = 1'b0;
      end else begin
        prev = out_data;
        have_prev = 1'b1;
      end
      tick();
      cyc++;
    end
    if (j < 16) chk("drain_timeout", j, 16);
    out_ready = 1'b0;
    exp_frames = exp_frames + 16'd1;
    chk("out_valid_after", out_valid, 1'b0);
    chk("in_ready_after", in_ready, 1'b1);
    chk("frames_done", frames_done, exp_frames);
  endtask

  initial begin
    @(negedge clk);
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'd0);
    chk("rst_blk_out", blk_out, 128'd0);
    chk("rst_key_out", key_out, 10'd0);
    chk("rst_mode_out", mode_out, 1'b0);
    chk("rst_frames", frames_done, 16'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // Single frame, bytes 0x00..0x0F.
    for (int i = 0; i < 16; i++) fb[i] = 8'(i);
    run_frame(fb, 10'h2B7, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Backpressure with random data.
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    run_frame(fb, 10'h155, 1'b1, 1'b0, 1, 1'b0, 1'b0);

    // Back-to-back frames with in_valid held high.
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    nxt_byte0 = 8'h5C;
    nxt_key   = 10'h0F0;
    nxt_mode  = 1'b1;
    run_frame(fb, 10'h201, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    fb[0] = 8'h5C;
    run_frame(fb, 10'h0F0, 1'b1, 1'b0, 0, 1'b1, 1'b0);

    // Random input stalls and random output ready.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
      run_frame(fb, 10'($urandom), 1'($urandom), 1'b1, 2, 1'b0, 1'b0);
    end

    // Reset after input byte 9.
    for (int i = 0; i < 10; i++) begin
      in_data  = 8'($urandom);
      in_valid = 1'b1;
      key_in   = 10'h3AA;
      tick();
    end
    in_valid = 1'b0;
    chk("midframe_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_blk", blk_out, 128'd0);
    rst_n = 1'b1;
    exp_frames = 16'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("aborted_no_output", out_valid, 1'b0);
      chk("aborted_not_busy", busy, 1'b0);
    end
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    run_frame(fb, 10'h099, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // frames_done wrap.
    force dut.r_frames_done = 16'hFFFF;
    tick();
    release dut.r_frames_done;
    tick();
    exp_frames = 16'hFFFF;
    chk("preload_frames", frames_done, exp_frames);
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    run_frame(fb, 10'h1C3, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("wrap_zero", frames_done, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
